// File: rtl/cpu_pkg.sv
// cpu_pkg: shared operand-extension modes and default datapath width.
package cpu_pkg;
    localparam int EXT_DATA_W = 16;
    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_PASS = 2'd2
    } ext_mode_t;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational sign/zero/pass extension above a selectable MSB.
module ext_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = EXT_DATA_W,
    parameter int MSB_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] shifted,
    input  logic [MSB_W-1:0]  msb,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data
);
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] above;
    assign hi = {DATA_W{1'b1}} << msb;
    // shifting once more clears to zero at msb = DATA_W-1, so ZERO keeps all bits
    assign above = hi << 1;
    assign data = mode == EXT_SIGN ? (shifted[msb] ? shifted | hi : shifted & ~hi)
                : mode == EXT_ZERO ? shifted & ~above
                : shifted;
endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: two-stage valid/ready operand extender (shift + overflow, then extend).
module ext_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W  = EXT_DATA_W,
    parameter int MSB_W   = $clog2(DATA_W),
    parameter int SHIFT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [MSB_W-1:0]   in_msb,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_ovf
);
    localparam int MAX_SH = (1 << SHIFT_W) - 1;
    logic [DATA_W+MAX_SH-1:0] wide;
    logic                     s1_valid;
    logic [DATA_W-1:0]        s1_shifted;
    logic [MSB_W-1:0]         s1_msb;
    logic [1:0]               s1_mode;
    logic                     s1_ovf;
    logic [DATA_W-1:0]        ext_data;
    logic                     s1_en;
    logic                     s2_en;
    // bits pushed above DATA_W-1 land in the extra top bits of wide
    assign wide     = {{MAX_SH{1'b0}}, in_data} << in_shift;
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    ext_core #(.DATA_W(DATA_W), .MSB_W(MSB_W)) core (
        .shifted (s1_shifted),
        .msb     (s1_msb),
        .mode    (s1_mode),
        .data    (ext_data)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_shifted <= '0;
            s1_msb     <= '0;
            s1_mode    <= '0;
            s1_ovf     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_shifted <= wide[DATA_W-1:0];
                    s1_ovf     <= |wide[DATA_W+MAX_SH-1:DATA_W];
                    s1_msb     <= in_msb;
                    s1_mode    <= in_mode;
                end
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= ext_data;
                    out_ovf  <= s1_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scoreboard bench for ext_pipe with directed, hand-computed vectors.
module tb_ext_pipe;
    import cpu_pkg::*;
    typedef struct {
        logic [15:0] d;
        logic        o;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_msb = '0;
    logic [1:0]  in_shift = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_ovf;
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    bit          drv_done;
    always #5 clk = ~clk;
    ext_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_msb    (in_msb),
        .in_shift  (in_shift),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // call #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [15:0] d, input logic [3:0] m, input logic [1:0] s,
                        input logic [1:0] md, input logic [15:0] ed, input logic eo);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_msb   = m;
        in_shift = s;
        in_mode  = md;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            q.push_back('{ed, eo});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", {15'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_data", out_data, e.d);
                check("out_ovf", out_ovf, e.o);
            end
        end
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0040, 4'd6, 2'd0, EXT_SIGN, 16'hFFC0, 1'b0);
        check("lat_s1_only", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 16'hFFC0);
        drain();
        send(16'h0040, 4'd7, 2'd1, EXT_SIGN, 16'hFF80, 1'b0);
        send(16'hFFC5, 4'd7, 2'd0, EXT_ZERO, 16'h00C5, 1'b0);
        send(16'h1234, 4'd0, 2'd0, EXT_PASS, 16'h1234, 1'b0);
        send(16'h8001, 4'd15, 2'd1, EXT_SIGN, 16'h0002, 1'b1);
        send(16'h8001, 4'd15, 2'd0, EXT_SIGN, 16'h8001, 1'b0);
        send(16'h2001, 4'd15, 2'd3, EXT_PASS, 16'h0008, 1'b1);
        send(16'h1001, 4'd15, 2'd3, EXT_PASS, 16'h8008, 1'b0);
        send(16'hABCD, 4'd15, 2'd0, EXT_ZERO, 16'hABCD, 1'b0);
        send(16'h5A5A, 4'd3, 2'd0, 2'd3, 16'h5A5A, 1'b0);
        send(16'h0001, 4'd0, 2'd0, EXT_SIGN, 16'hFFFF, 1'b0);
        send(16'h0002, 4'd0, 2'd0, EXT_SIGN, 16'h0000, 1'b0);
        send(16'h00F3, 4'd2, 2'd0, EXT_ZERO, 16'h0003, 1'b0);
        drain();
        // stall: four requests against a blocked consumer
        out_ready = 1'b0;
        drv_done  = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(16'(i), 4'd0, 2'd0, EXT_PASS, 16'(i), 1'b0);
                drv_done = 1'b1;
            end
        join_none
        @(posedge clk);
        @(posedge clk);
        #1;
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, 1);
        @(posedge clk);
        #1;
        check("stall_hold", out_data, 1);
        check("stall_in_ready2", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_gap", out_valid, 1);
        end
        wait (drv_done);
        drain();
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 4'd0, 2'd0, EXT_PASS, 16'h0100 + 16'(i), 1'b0);
                drv_done = 1'b1;
            end
        join_none
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("stream_start", out_valid, 1);
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                check("stream_cont", out_valid, 1);
            end
        end
        wait (drv_done);
        drain();
        // reset with both stages occupied
        out_ready = 1'b0;
        drv_done  = 1'b0;
        fork
            begin
                send(16'h8001, 4'd0, 2'd1, EXT_PASS, 16'h0002, 1'b1);
                send(16'h00AA, 4'd0, 2'd0, EXT_PASS, 16'h00AA, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        begin
            int n = 0;
            @(negedge clk);
            while (in_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("full_before_rst", in_ready, 0);
        end
        wait (drv_done);
        check("pre_rst_ovf", out_ovf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ovf", out_ovf, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", out_valid, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
